// File: rtl/ch_sample_sequencer.sv
// ============================================================================
// Module   : ch_sample_sequencer
// Brief    : Per-channel sampling sequencer. Splits the four sampling banks
//            into capture groups according to the latched mode, fires each
//            group's start pulse in turn, collects per-bank completion and
//            holds the channel full until readout releases it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ch_sample_sequencer_pkg;
  typedef enum logic [1:0] {
    MODE_SAMPLE1 = 2'b00,
    MODE_SAMPLE2 = 2'b01,
    MODE_RSVD    = 2'b10,
    MODE_SAMPLE4 = 2'b11
  } smode_t;
endpackage

module ch_sample_sequencer
  import ch_sample_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023,
  parameter int TMR_W       = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       INST_START,
  input  smode_t     MODE,
  input  logic [3:0] BANK_DONE,
  input  logic       READ_DONE,
  input  logic       ABORT,
  output logic [3:0] BANK_START,
  output logic [3:0] ACTIVE_BANKS,
  output logic       BUSY,
  output logic       FULL,
  output logic [2:0] CAPT_CNT,
  output logic       TIMEOUT,
  output logic       INST_ERR
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ARM      = 2'd1;
  localparam logic [1:0] S_SAMPLING = 2'd2;
  localparam logic [1:0] S_FULL     = 2'd3;

  localparam logic [TMR_W-1:0] TMO_VAL = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  // Bank mask of group g under mode m; the reserved encoding behaves as SAMPLE4
  function automatic logic [3:0] grp_mask(input smode_t m, input logic [1:0] g);
    logic [3:0] r;
    r = 4'b1111;
    case (m)
      MODE_SAMPLE1: r = 4'b0001 << g;
      MODE_SAMPLE2: r = g[0] ? 4'b1100 : 4'b0011;
      default:      r = 4'b1111;
    endcase
    return r;
  endfunction

  // Index of the final group under mode m
  function automatic logic [1:0] last_grp(input smode_t m);
    logic [1:0] r;
    r = 2'd0;
    case (m)
      MODE_SAMPLE1: r = 2'd3;
      MODE_SAMPLE2: r = 2'd1;
      default:      r = 2'd0;
    endcase
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic             inst_q;
  smode_t           mode_q, mode_d;
  logic [1:0]       grp_q, grp_d;
  logic [3:0]       done_q, done_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       capt_q, capt_d;
  logic             tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [3:0]       bstart_q, bstart_d;

  logic             start_edge;
  logic [3:0]       cur_mask;
  logic             grp_cover;

  assign start_edge = INST_START & ~inst_q;
  assign cur_mask   = grp_mask(mode_q, grp_q);
  // Done bits seen earlier plus this cycle's pulses must cover the whole group
  assign grp_cover  = (((done_q | BANK_DONE) & cur_mask) == cur_mask);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: edge detect, run context, counters, registered start pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_q   <= 1'b0;
      mode_q   <= MODE_SAMPLE4;
      grp_q    <= 2'd0;
      done_q   <= 4'd0;
      tmr_q    <= '0;
      capt_q   <= 3'd0;
      tmo_q    <= 1'b0;
      err_q    <= 1'b0;
      bstart_q <= 4'd0;
    end else begin
      inst_q   <= INST_START;
      mode_q   <= mode_d;
      grp_q    <= grp_d;
      done_q   <= done_d;
      tmr_q    <= tmr_d;
      capt_q   <= capt_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      bstart_q <= bstart_d;
    end
  end

  // Next-state and datapath update; ABORT overrides everything at the end
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    grp_d    = grp_q;
    done_d   = done_q;
    tmr_d    = tmr_q;
    capt_d   = capt_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    bstart_d = 4'd0;

    if (start_edge && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_ARM;
          mode_d  = MODE;
          grp_d   = 2'd0;
          capt_d  = 3'd0;
          tmo_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_ARM: begin
        done_d  = 4'd0;
        tmr_d   = '0;
        state_d = S_SAMPLING;
      end
      S_SAMPLING: begin
        done_d = done_q | (BANK_DONE & cur_mask);
        tmr_d  = tmr_q + TMR_ONE;
        // Completion takes precedence over a coincident timeout
        if (grp_cover) begin
          capt_d = capt_q + 3'd1;
          if (grp_q == last_grp(mode_q)) begin
            state_d = S_FULL;
          end else begin
            grp_d   = grp_q + 2'd1;
            state_d = S_ARM;
          end
        end else if (tmr_q == TMO_VAL) begin
          tmo_d   = 1'b1;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (READ_DONE) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ABORT) begin
      state_d = S_IDLE;
      capt_d  = 3'd0;
      tmo_d   = 1'b0;
      grp_d   = 2'd0;
      err_d   = err_q;
    end

    // The start pulse is registered so it is high exactly while in ARM
    if (state_d == S_ARM) begin
      bstart_d = grp_mask(mode_d, grp_d);
    end
  end

  // Output decode
  always_comb begin
    BANK_START   = bstart_q;
    ACTIVE_BANKS = (state_q == S_SAMPLING) ? cur_mask : 4'd0;
    BUSY         = (state_q != S_IDLE);
    FULL         = (state_q == S_FULL);
    CAPT_CNT     = capt_q;
    TIMEOUT      = tmo_q;
    INST_ERR     = err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ch_sample_sequencer.sv
// ============================================================================
// Module   : tb_ch_sample_sequencer
// Brief    : Directed self-checking bench for ch_sample_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ch_sample_sequencer;
  import ch_sample_sequencer_pkg::*;

  logic       clk;
  logic       rstn;
  logic       inst_start;
  smode_t     mode;
  logic [3:0] bank_done;
  logic       read_done;
  logic       abort_s;
  logic [3:0] bank_start;
  logic [3:0] active_banks;
  logic       busy;
  logic       full;
  logic [2:0] capt_cnt;
  logic       timeout;
  logic       inst_err;

  int n_checks = 0;
  int n_fail   = 0;

  ch_sample_sequencer #(
    .TIMEOUT_CYC(15),
    .TMR_W      (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .INST_START  (inst_start),
    .MODE        (mode),
    .BANK_DONE   (bank_done),
    .READ_DONE   (read_done),
    .ABORT       (abort_s),
    .BANK_START  (bank_start),
    .ACTIVE_BANKS(active_banks),
    .BUSY        (busy),
    .FULL        (full),
    .CAPT_CNT    (capt_cnt),
    .TIMEOUT     (timeout),
    .INST_ERR    (inst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse a start edge; on return the DUT is in ARM
  task automatic start_run(input smode_t m);
    mode       = m;
    inst_start = 1'b1;
    step();
    inst_start = 1'b0;
  endtask

  task automatic readout();
    read_done = 1'b1;
    step();
    read_done = 1'b0;
  endtask

  initial begin
    rstn       = 1'b0;
    inst_start = 1'b0;
    mode       = MODE_SAMPLE1;
    bank_done  = 4'd0;
    read_done  = 1'b0;
    abort_s    = 1'b0;
    #23;
    check("rst_bstart", 32'(bank_start), 32'h0);
    check("rst_busy",   32'(busy),       32'h0);
    check("rst_full",   32'(full),       32'h0);
    check("rst_capt",   32'(capt_cnt),   32'h0);
    check("rst_err",    32'(inst_err),   32'h0);
    rstn = 1'b1;
    step();
    check("idle_bstart", 32'(bank_start), 32'h0);

    // SAMPLE4: single 1111 group
    start_run(MODE_SAMPLE4);
    check("s4_bstart", 32'(bank_start), 32'hF);
    check("s4_busy",   32'(busy),       32'h1);
    step();
    check("s4_bstart_off", 32'(bank_start),   32'h0);
    check("s4_active",     32'(active_banks), 32'hF);
    repeat (4) step();
    bank_done = 4'hF;
    step();
    bank_done = 4'h0;
    check("s4_full",   32'(full),         32'h1);
    check("s4_capt",   32'(capt_cnt),     32'h1);
    check("s4_act0",   32'(active_banks), 32'h0);
    readout();
    check("s4_busy_rel", 32'(busy),     32'h0);
    check("s4_full_rel", 32'(full),     32'h0);
    check("s4_capt_ret", 32'(capt_cnt), 32'h1);

    // SAMPLE1: four single-bank groups, out-of-order done ignored
    start_run(MODE_SAMPLE1);
    check("s1_bs0",   32'(bank_start), 32'h1);
    check("s1_capt0", 32'(capt_cnt),   32'h0);
    step();
    bank_done = 4'b0100;
    step();
    check("s1_ign_act", 32'(active_banks), 32'h1);
    check("s1_ign_bs",  32'(bank_start),   32'h0);
    bank_done = 4'b0001;
    step();
    check("s1_bs1",   32'(bank_start), 32'h2);
    check("s1_capt1", 32'(capt_cnt),   32'h1);
    bank_done = 4'b0000;
    step();
    check("s1_act1", 32'(active_banks), 32'h2);
    bank_done = 4'b0010;
    step();
    check("s1_bs2", 32'(bank_start), 32'h4);
    bank_done = 4'b0000;
    step();
    read_done = 1'b1;
    step();
    read_done = 1'b0;
    check("s1_rd_ign_busy", 32'(busy),         32'h1);
    check("s1_act2",        32'(active_banks), 32'h4);
    bank_done = 4'b0100;
    step();
    check("s1_bs3",   32'(bank_start), 32'h8);
    check("s1_capt3", 32'(capt_cnt),   32'h3);
    bank_done = 4'b0000;
    step();
    bank_done = 4'b1000;
    step();
    bank_done = 4'b0000;
    check("s1_full", 32'(full),     32'h1);
    check("s1_capt", 32'(capt_cnt), 32'h4);
    readout();

    // SAMPLE2: group 1 only after both bank 0 and 1 seen; start edge mid-run
    start_run(MODE_SAMPLE2);
    check("s2_bs0", 32'(bank_start), 32'h3);
    step();
    bank_done = 4'b0001;
    step();
    check("s2_wait_bs",  32'(bank_start),   32'h0);
    check("s2_wait_act", 32'(active_banks), 32'h3);
    bank_done = 4'b0010;
    step();
    check("s2_bs1",   32'(bank_start), 32'hC);
    check("s2_capt1", 32'(capt_cnt),   32'h1);
    bank_done = 4'b0000;
    step();
    inst_start = 1'b1;
    step();
    inst_start = 1'b0;
    check("s2_err",     32'(inst_err),     32'h1);
    check("s2_err_act", 32'(active_banks), 32'hC);
    bank_done = 4'b1100;
    step();
    bank_done = 4'b0000;
    check("s2_full", 32'(full),     32'h1);
    check("s2_capt", 32'(capt_cnt), 32'h2);
    readout();

    // Reserved encoding behaves as SAMPLE4; new start clears INST_ERR
    start_run(smode_t'(2'b10));
    check("rsv_bs",  32'(bank_start), 32'hF);
    check("rsv_err", 32'(inst_err),   32'h0);
    step();
    bank_done = 4'hF;
    step();
    bank_done = 4'h0;
    check("rsv_full", 32'(full),     32'h1);
    check("rsv_capt", 32'(capt_cnt), 32'h1);
    readout();

    // Timeout in group 1 of SAMPLE2
    start_run(MODE_SAMPLE2);
    step();
    bank_done = 4'b0011;
    step();
    bank_done = 4'b0000;
    check("to_bs1", 32'(bank_start), 32'hC);
    step();
    repeat (15) step();
    check("to_pre_full", 32'(full),         32'h0);
    check("to_pre_to",   32'(timeout),      32'h0);
    check("to_pre_act",  32'(active_banks), 32'hC);
    step();
    check("to_full", 32'(full),       32'h1);
    check("to_to",   32'(timeout),    32'h1);
    check("to_capt", 32'(capt_cnt),   32'h1);
    check("to_bs",   32'(bank_start), 32'h0);
    step();
    check("to_norestart", 32'(bank_start), 32'h0);
    readout();

    // Completion on the timeout cycle wins
    start_run(MODE_SAMPLE4);
    check("tw_to_clr", 32'(timeout), 32'h0);
    step();
    repeat (15) step();
    bank_done = 4'hF;
    step();
    bank_done = 4'h0;
    check("tw_full", 32'(full),     32'h1);
    check("tw_to",   32'(timeout),  32'h0);
    check("tw_capt", 32'(capt_cnt), 32'h1);
    readout();

    // ABORT mid-SAMPLING keeps INST_ERR, clears CAPT_CNT
    start_run(MODE_SAMPLE1);
    step();
    bank_done = 4'b0001;
    step();
    bank_done = 4'b0000;
    step();
    inst_start = 1'b1;
    step();
    inst_start = 1'b0;
    abort_s    = 1'b1;
    step();
    abort_s    = 1'b0;
    check("ab_busy", 32'(busy),         32'h0);
    check("ab_capt", 32'(capt_cnt),     32'h0);
    check("ab_err",  32'(inst_err),     32'h1);
    check("ab_act",  32'(active_banks), 32'h0);

    // Asynchronous reset during ARM
    start_run(MODE_SAMPLE4);
    check("ar_bs_pre", 32'(bank_start), 32'hF);
    rstn = 1'b0;
    #1;
    check("ar_bs",   32'(bank_start), 32'h0);
    check("ar_busy", 32'(busy),       32'h0);
    check("ar_err",  32'(inst_err),   32'h0);
    #1;
    rstn = 1'b1;
    step();
    step();
    check("ar_nopulse", 32'(bank_start), 32'h0);
    check("ar_idle",    32'(busy),       32'h0);

    // Start held high across reset release counts as an edge
    inst_start = 1'b1;
    rstn       = 1'b0;
    #2;
    rstn = 1'b1;
    step();
    check("hold_bs", 32'(bank_start), 32'hF);
    inst_start = 1'b0;
    abort_s    = 1'b1;
    step();
    abort_s    = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
